// File: rtl/mul_div_unit_pkg.sv
// Shared RV32M encodings: funct3 opcodes, FSM states and the RISC-V special-case result constants.
// The operand-signedness decode lives here so every consumer agrees on it.
package mul_div_unit_pkg;

    localparam int unsigned XLEN_RV = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam logic [XLEN_RV-1:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [XLEN_RV-1:0] MIN_INT  = 32'h8000_0000;

    function automatic logic op_a_signed(input logic [2:0] f3);
        return !((f3 == F3_MULHU) || (f3 == F3_DIVU) || (f3 == F3_REMU));
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or restoring shift-subtract divide.
// Accumulator layout is {hi, lo}: multiplier / quotient bits live in lo, partial product / remainder in hi.
module mul_div_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    input  logic              i_div,
    output logic [2*XLEN-1:0] o_acc
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    always_comb begin
        w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
        w_shift = i_acc[2*XLEN-1:XLEN-1];
        w_ge    = (w_shift >= {1'b0, i_opnd});
        // A successful subtract always leaves less than the divisor, so XLEN bits suffice.
        w_diff  = w_shift[XLEN-1:0] - i_opnd;
        if (i_div) begin
            if (w_ge) begin
                o_acc = {w_diff, i_acc[XLEN-2:0], 1'b1};
            end else begin
                o_acc = {w_shift[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_sum, i_acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: XLEN iterations on magnitudes,
// then a single sign-fix cycle, then a one-cycle DONE pulse with a registered RESULT.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            KILL,
    input  logic [2:0]      FUN3,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opnd;
    logic [2:0]          r_fun3;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_special;
    logic [XLEN-1:0]     r_spec_res;
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_result;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_dz;
    logic                w_ovf;
    logic [XLEN-1:0]     w_spec_res;
    logic [2*XLEN-1:0]   w_step_acc;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_res;

    always_comb begin
        w_a_neg    = op_a_signed(FUN3) & RS1[XLEN-1];
        w_b_neg    = op_b_signed(FUN3) & RS2[XLEN-1];
        w_a_mag    = w_a_neg ? (~RS1 + 1'b1) : RS1;
        w_b_mag    = w_b_neg ? (~RS2 + 1'b1) : RS2;
        w_dz       = FUN3[2] && (RS2 == '0);
        w_ovf      = FUN3[2] && !FUN3[0] && (RS1 == MIN_INT) && (RS2 == ALL_ONES);
        // Overflow: div returns the dividend (MIN_INT), rem returns 0.
        if (FUN3[1]) begin
            w_spec_res = w_dz ? RS1 : '0;
        end else begin
            w_spec_res = w_dz ? ALL_ONES : MIN_INT;
        end
    end

    mul_div_step #(.XLEN(XLEN)) u_step (
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .i_div  (r_fun3[2]),
        .o_acc  (w_step_acc)
    );

    always_comb begin
        w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
        w_quo  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
        w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
        case (r_fun3)
            F3_MUL:                     w_fix_res = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:            w_fix_res = w_quo;
            default:                    w_fix_res = w_rem;
        endcase
        if (r_special) begin
            w_fix_res = r_spec_res;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_fun3     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
        end else if (KILL) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_fun3     <= FUN3;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_special  <= w_dz | w_ovf;
                        r_spec_res <= w_spec_res;
                        r_cnt      <= CNT_W'(XLEN);
                        r_busy     <= 1'b1;
                        // Multiply keeps the multiplier in lo; divide shifts the dividend out of lo.
                        if (FUN3[2]) begin
                            r_acc  <= {{XLEN{1'b0}}, w_a_mag};
                            r_opnd <= w_b_mag;
                        end else begin
                            r_acc  <= {{XLEN{1'b0}}, w_b_mag};
                            r_opnd <= w_a_mag;
                        end
                        r_state <= (w_dz | w_ovf) ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= w_fix_res;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= ST_OUT;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign RESULT = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a table of hand-computed RV32M results and latencies,
// followed by sequences for KILL, START held high and reset in mid-operation.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        KILL;
    logic [2:0]  FUN3;
    logic [31:0] RS1;
    logic [31:0] RS2;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;

    mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .KILL   (KILL),
        .FUN3   (FUN3),
        .RS1    (RS1),
        .RS2    (RS2),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        FUN3  = f3;
        RS1   = a;
        RS2   = b;
        START = 1'b1;
        cyc   = 0;
        next_cycle();
        START = 1'b0;
        RS1   = ~a;
        RS2   = ~b;
        FUN3  = ~f3;
    endtask

    // Returns with the clock at the falling edge of the DONE cycle, or lat=-1 once cyc passes limit.
    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        while (cyc <= limit) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                lat = cyc;
                break;
            end
            next_cycle();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int busy_cnt;
        int dones;
        logic [31:0] held_res;

        vecs.push_back('{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3"});
        vecs.push_back('{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min_min"});
        vecs.push_back('{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_ones"});
        vecs.push_back('{F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34, "mulhsu_m1_2"});
        vecs.push_back('{F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "mulhsu_min_umax"});
        vecs.push_back('{F3_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh_min_m1"});
        vecs.push_back('{F3_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 34, "mulhu_2p16_sq"});
        vecs.push_back('{F3_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 34, "mul_2p16_sq"});
        vecs.push_back('{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, "div_m7_2"});
        vecs.push_back('{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, "rem_m7_2"});
        vecs.push_back('{F3_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2"});
        vecs.push_back('{F3_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34, "rem_7_m2"});
        vecs.push_back('{F3_DIVU,   32'd100,       32'd7,         32'd14,        34, "divu_100_7"});
        vecs.push_back('{F3_REMU,   32'd100,       32'd7,         32'd2,         34, "remu_100_7"});
        vecs.push_back('{F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 2,  "div_by0"});
        vecs.push_back('{F3_REM,    32'd5,         32'd0,         32'd5,         2,  "rem_by0"});
        vecs.push_back('{F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2,  "divu_by0"});
        vecs.push_back('{F3_REMU,   32'd5,         32'd0,         32'd5,         2,  "remu_by0"});
        vecs.push_back('{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  "div_ovf"});
        vecs.push_back('{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2,  "rem_ovf"});

        RST = 1'b1; START = 1'b0; KILL = 1'b0; FUN3 = 3'b000; RS1 = '0; RS2 = '0;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_result", RESULT, 32'd0);
        next_cycle();
        RST = 1'b0;
        next_cycle();

        // Detailed timing of the first multiply.
        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD);
        busy_cnt = 0;
        lat = -1;
        while (cyc <= 35) begin
            @(negedge CLK);
            if (cyc <= 33 && BUSY === 1'b1) busy_cnt++;
            if (cyc == 34) begin
                check("t_busy_at34", 32'(BUSY), 32'd0);
                check("t_done_at34", 32'(DONE), 32'd1);
                check("t_result_at34", RESULT, 32'hFFFF_FFEB);
            end
            if (cyc == 35) check("t_done_at35", 32'(DONE), 32'd0);
            next_cycle();
        end
        check("t_busy_cycles", busy_cnt, 32'd33);

        foreach (vecs[i]) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b);
            wait_done(60, lat);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_res"}, RESULT, vecs[i].exp);
            next_cycle();
            @(negedge CLK);
            check({vecs[i].name, "_done_low"}, 32'(DONE), 32'd0);
            next_cycle();
        end

        // KILL mid-multiply keeps the previous result and produces no DONE.
        issue(F3_DIVU, 32'd100, 32'd7);
        wait_done(60, lat);
        check("k_prev_res", RESULT, 32'd14);
        next_cycle();
        next_cycle();
        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD);
        while (cyc < 10) next_cycle();
        KILL = 1'b1;
        next_cycle();
        KILL = 1'b0;
        @(negedge CLK);
        check("k_busy_at11", 32'(BUSY), 32'd0);
        check("k_done_at11", 32'(DONE), 32'd0);
        check("k_result_kept", RESULT, 32'd14);
        next_cycle();
        issue(F3_MUL, 32'd3, 32'd5);
        wait_done(60, lat);
        check("k_restart_lat", lat, 32'd34);
        check("k_restart_res", RESULT, 32'd15);
        next_cycle();
        next_cycle();

        // KILL and START together: the op must not be accepted.
        FUN3 = F3_MUL; RS1 = 32'd2; RS2 = 32'd2; START = 1'b1; KILL = 1'b1;
        next_cycle();
        START = 1'b0; KILL = 1'b0;
        @(negedge CLK);
        check("ks_busy", 32'(BUSY), 32'd0);
        next_cycle();

        // START held high with changing operands: only the first op runs.
        FUN3 = F3_MUL; RS1 = 32'd7; RS2 = 32'hFFFF_FFFD; START = 1'b1;
        cyc = 0;
        next_cycle();
        dones = 0;
        lat = -1;
        held_res = '0;
        while (cyc <= 40) begin
            RS1 = 32'(cyc) * 32'd13;
            RS2 = 32'(cyc) + 32'd3;
            FUN3 = 3'(cyc);
            if (cyc >= 35) START = 1'b0;
            @(negedge CLK);
            if (DONE === 1'b1) begin
                dones++;
                lat = cyc;
                held_res = RESULT;
            end
            next_cycle();
        end
        START = 1'b0;
        check("h_done_count", dones, 32'd1);
        check("h_lat", lat, 32'd34);
        check("h_res", held_res, 32'hFFFF_FFEB);

        // Reset in the middle of an operation.
        issue(F3_MUL, 32'd9, 32'd9);
        while (cyc < 20) next_cycle();
        RST = 1'b1;
        next_cycle();
        @(negedge CLK);
        check("r_busy", 32'(BUSY), 32'd0);
        check("r_done", 32'(DONE), 32'd0);
        check("r_result", RESULT, 32'd0);
        next_cycle();
        RST = 1'b0;
        wait_done(cyc + 40, lat);
        check("r_no_done", lat, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative RV32M execute unit that consumes decoded instructions whose ALU_CNT is alu_mstd.
It sits in the EX stage beside the main ALU and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU from FUN3, RS1 and RS2.
While it works it raises BUSY so the pipeline control holds ID/EX.
It returns a registered RESULT with a one-cycle DONE pulse.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
CLK     input   1      clock; all state updates on rising edge
RST     input   1      synchronous reset, active-high
START   input   1      EX holds an alu_mstd op with valid operands; sampled only in IDLE
KILL    input   1      pipeline flush; aborts any operation in progress
FUN3    input   3      000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
RS1     input   XLEN   operand a (multiplicand / dividend)
RS2     input   XLEN   operand b (multiplier / divisor)
BUSY    output  1      high from the cycle after START is accepted until DONE
DONE    output  1      one-cycle pulse; RESULT is valid in this cycle
RESULT  output  XLEN   result; held until the next accepted START

Behaviour:
- Reset: state IDLE; BUSY=0, DONE=0, RESULT=0; counter and datapath registers 0.
- Reset asserted mid-operation: same as above on the next edge; no DONE is produced.
- FSM states: IDLE, CALC, FIX, OUT.
- IDLE:
  - If START=1 and KILL=0, latch FUN3.
  - Latch the operand magnitudes and the result sign:
    - mulh and div/rem: both operands signed.
    - mulhsu: RS1 signed, RS2 unsigned.
    - mulhu/divu/remu: both unsigned.
    - mul: magnitudes of signed operands; the low word is identical either way.
  - Load counter = XLEN and go to CALC.
  - Special cases skip CALC and go straight to FIX:
    - Divide by zero (RS2=0, FUN3[2]=1).
    - Signed overflow (div/rem with RS1=0x80000000 and RS2=0xFFFFFFFF).
- CALC: one iteration per cycle; the counter decrements; go to FIX when the counter reaches 1 on this edge (exactly XLEN cycles).
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract; quotient and remainder registers.
- FIX:
  - Apply two's-complement sign correction:
    - Product: sign = sign(a) xor sign(b), for the signed forms.
    - Quotient: sign = sign(a) xor sign(b).
    - Remainder: takes the sign of the dividend.
  - Select low word (mul), high word (mulh*), quotient or remainder.
  - Register RESULT; go to OUT.
- OUT: DONE=1 for exactly one cycle, BUSY=0 in this cycle; go to IDLE. A START in the OUT cycle is ignored.
- Latency:
  - START accepted at cycle 0 gives DONE at cycle XLEN+2 (34).
  - Special-case divides give DONE at cycle 2.
- Special-case results (RISC-V defined):
  - div/divu by 0: RESULT=0xFFFFFFFF.
  - rem/remu by 0: RESULT=RS1.
  - Overflow: div gives 0x80000000, rem gives 0.
- START while BUSY=1: ignored, with no effect on the operation in flight.
- KILL:
  - In any state: next state IDLE, BUSY=0, no DONE, RESULT unchanged.
  - KILL and START in the same cycle: KILL wins, the op is not accepted.
- Operands are sampled only at acceptance; RS1/RS2/FUN3 may change afterwards.

Decomposition:
- The funct3 encodings for mul..remu are already in the shared PipelineParams.vh header; reuse those.
- Add the FSM state encodings and the special-case constants (all-ones, min-int) to that header.
- One natural combinational sub-module, mul_div_step: performs one shift-add or restore-subtract iteration from {acc, operand, mode} and returns {acc_next}. The FSM and sign logic stay in mul_div_unit.

Test Plan:
- mul RS1=7, RS2=0xFFFFFFFD (−3), START at cycle 0 -> BUSY cycles 1-33, DONE at cycle 34 with RESULT=0xFFFFFFEB, DONE low at cycle 35.
- mulh 0x80000000 x 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- div 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD; rem the same operands -> 0xFFFFFFFF; divu 100/7 -> 14; remu 100/7 -> 2.
- Special cases:
  - div 5/0 -> 0xFFFFFFFF.
  - rem 5/0 -> 5.
  - div 0x80000000/0xFFFFFFFF -> 0x80000000.
  - rem of the same operands -> 0.
  - Each special case gives DONE at cycle 2.
- KILL at cycle 10 of a mul -> BUSY=0 at cycle 11, no DONE, RESULT keeps its previous value. A new START at cycle 12 -> DONE at cycle 46 with the correct result.
- START held high through the whole op with different operands -> only the first op is computed, with a single DONE. Reset asserted at cycle 20 -> all outputs 0 on the next edge.
